// File: rtl/ca_code_gen_pkg.sv
// GPS L1 C/A constants: code geometry, LFSR feedback masks and the G2 phase-select table.
// Pure declarations; no latency or backpressure of its own.
package ca_code_gen_pkg;

    localparam int         CODE_LENGTH_DEF = 1023;
    localparam int         INDEX_WIDTH_DEF = 10;
    localparam logic [9:0] LFSR_INIT       = 10'h3FF;

    // Bit n-1 holds register stage n.
    localparam logic [9:0] G1_MASK = 10'h204;  // stages 3,10
    localparam logic [9:0] G2_MASK = 10'h3A6;  // stages 2,3,6,8,9,10

    typedef struct packed {
        logic       vld;
        logic [3:0] ta;
        logic [3:0] tb;
    } tap_pair_t;

    // G2 stage pair (1-based) for each PRN; vld=0 marks an unsupported PRN.
    function automatic tap_pair_t g2_taps(input logic [5:0] prn);
        tap_pair_t t;
        t = '{vld: 1'b1, ta: 4'd0, tb: 4'd0};
        case (prn)
            6'd1:  begin t.ta = 4'd2; t.tb = 4'd6;  end
            6'd2:  begin t.ta = 4'd3; t.tb = 4'd7;  end
            6'd3:  begin t.ta = 4'd4; t.tb = 4'd8;  end
            6'd4:  begin t.ta = 4'd5; t.tb = 4'd9;  end
            6'd5:  begin t.ta = 4'd1; t.tb = 4'd9;  end
            6'd6:  begin t.ta = 4'd2; t.tb = 4'd10; end
            6'd7:  begin t.ta = 4'd1; t.tb = 4'd8;  end
            6'd8:  begin t.ta = 4'd2; t.tb = 4'd9;  end
            6'd9:  begin t.ta = 4'd3; t.tb = 4'd10; end
            6'd10: begin t.ta = 4'd2; t.tb = 4'd3;  end
            6'd11: begin t.ta = 4'd3; t.tb = 4'd4;  end
            6'd12: begin t.ta = 4'd5; t.tb = 4'd6;  end
            6'd13: begin t.ta = 4'd6; t.tb = 4'd7;  end
            6'd14: begin t.ta = 4'd7; t.tb = 4'd8;  end
            6'd15: begin t.ta = 4'd8; t.tb = 4'd9;  end
            6'd16: begin t.ta = 4'd9; t.tb = 4'd10; end
            6'd17: begin t.ta = 4'd1; t.tb = 4'd4;  end
            6'd18: begin t.ta = 4'd2; t.tb = 4'd5;  end
            6'd19: begin t.ta = 4'd3; t.tb = 4'd6;  end
            6'd20: begin t.ta = 4'd4; t.tb = 4'd7;  end
            6'd21: begin t.ta = 4'd5; t.tb = 4'd8;  end
            6'd22: begin t.ta = 4'd6; t.tb = 4'd9;  end
            6'd23: begin t.ta = 4'd1; t.tb = 4'd3;  end
            6'd24: begin t.ta = 4'd4; t.tb = 4'd6;  end
            6'd25: begin t.ta = 4'd5; t.tb = 4'd7;  end
            6'd26: begin t.ta = 4'd6; t.tb = 4'd8;  end
            6'd27: begin t.ta = 4'd7; t.tb = 4'd9;  end
            6'd28: begin t.ta = 4'd8; t.tb = 4'd10; end
            6'd29: begin t.ta = 4'd1; t.tb = 4'd6;  end
            6'd30: begin t.ta = 4'd2; t.tb = 4'd7;  end
            6'd31: begin t.ta = 4'd3; t.tb = 4'd8;  end
            6'd32: begin t.ta = 4'd4; t.tb = 4'd9;  end
            default: t = '{vld: 1'b0, ta: 4'd1, tb: 4'd1};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ca_code_gen_if.sv
// Control inputs and E/P/L code outputs of the C/A generator.
// Plain wires; no handshake, outputs are valid every cycle.
interface ca_code_gen_if
    import ca_code_gen_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) ();

    logic                   enable;
    logic                   dds_msb;
    logic                   load;
    logic [5:0]             prn;
    logic                   early;
    logic                   prompt;
    logic                   late;
    logic [INDEX_WIDTH-1:0] chip_index;
    logic                   epoch;

    modport master (
        output enable, dds_msb, load, prn,
        input  early, prompt, late, chip_index, epoch
    );

    modport slave (
        input  enable, dds_msb, load, prn,
        output early, prompt, late, chip_index, epoch
    );

endinterface

// File: rtl/ca_code_gen_lfsr_pair.sv
// G1/G2 Gold-code shift registers with step/reload; code_bit is combinational from current state.
// One step per asserted step cycle; reload wins over step; no backpressure.
module ca_code_gen_lfsr_pair
    import ca_code_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       reload,
    input  logic [5:0] prn,
    output logic       code_bit
);

    logic [9:0] g1;
    logic [9:0] g2;
    tap_pair_t  taps;

    always_ff @(posedge clk) begin
        if (!reset || reload) begin
            g1 <= LFSR_INIT;
            g2 <= LFSR_INIT;
        end else if (step) begin
            g1 <= {g1[8:0], ^(g1 & G1_MASK)};
            g2 <= {g2[8:0], ^(g2 & G2_MASK)};
        end
    end

    // Unsupported PRNs produce a flat-zero code rather than a wrong one.
    always_comb begin
        taps     = g2_taps(prn);
        code_bit = taps.vld & (g1[9] ^ g2[taps.ta - 4'd1] ^ g2[taps.tb - 4'd1]);
    end

endmodule

// File: rtl/ca_code_gen.sv
// C/A code generator: half-chip ticks from dds MSB rising edges drive early/prompt/late and chip index.
// Outputs update 1 clk after a rising dds_msb is sampled; enable=0 freezes all code state.
module ca_code_gen
    import ca_code_gen_pkg::*;
#(
    parameter int CODE_LENGTH = CODE_LENGTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ca_code_gen_if.slave   bus
);

    localparam logic [INDEX_WIDTH-1:0] LAST_CHIP = INDEX_WIDTH'(CODE_LENGTH - 1);

    logic                   msb_d;
    logic                   h;
    logic [5:0]             prn_q;
    logic [INDEX_WIDTH-1:0] chip_index;
    logic                   early;
    logic                   prompt;
    logic                   late;
    logic                   epoch;

    logic tick;
    logic at_last;
    logic step;
    logic reload;
    logic code_bit;

    assign tick    = bus.dds_msb & ~msb_d & bus.enable;
    assign at_last = (chip_index == LAST_CHIP);
    assign step    = tick & h & ~bus.load;
    // Realign both registers on the wrap so a glitch can never outlive one epoch.
    assign reload  = bus.load | (step & at_last);

    ca_code_gen_lfsr_pair u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .reload   (reload),
        .prn      (prn_q),
        .code_bit (code_bit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            msb_d      <= 1'b0;
            h          <= 1'b0;
            prn_q      <= 6'd1;
            chip_index <= '0;
            early      <= 1'b0;
            prompt     <= 1'b0;
            late       <= 1'b0;
            epoch      <= 1'b0;
        end else begin
            msb_d <= bus.dds_msb;
            if (bus.load) begin
                prn_q      <= bus.prn;
                h          <= 1'b0;
                chip_index <= '0;
                early      <= 1'b0;
                prompt     <= 1'b0;
                late       <= 1'b0;
                epoch      <= 1'b0;
            end else begin
                epoch <= tick & h & at_last;
                if (tick) begin
                    {late, prompt, early} <= {prompt, early, code_bit};
                    h <= ~h;
                    if (h) begin
                        chip_index <= at_last ? '0 : chip_index + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.early      = early;
    assign bus.prompt     = prompt;
    assign bus.late       = late;
    assign bus.chip_index = chip_index;
    assign bus.epoch      = epoch;

endmodule

// File: tb/tb_ca_code_gen.sv
// Scoreboard bench for ca_code_gen: a tick-count reference model predicts every cycle's outputs.
module tb_ca_code_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ca_code_gen_if #(.INDEX_WIDTH(10)) bus ();

    ca_code_gen #(.CODE_LENGTH(1023), .INDEX_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit e;
        bit p;
        bit l;
        bit ep;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Gold code per PRN, built from the shift-register definition; invalid PRNs stay all-zero.
    bit code_tab[64][1023];
    int tap_a[33] = '{0, 2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap_b[33] = '{0, 6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    // Reference model state: ticks since last restart, previous msb, current PRN.
    int n       = 0;
    bit msb_prev = 1'b0;
    int prn_m   = 1;
    bit ep_m    = 1'b0;

    bit obs_early;
    bit obs_any;
    int obs_idx;
    int epoch_seen = 0;

    function automatic bit mbit(int k);
        if (k < 0) return 1'b0;
        return code_tab[prn_m][(k / 2) % 1023];
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock of stimulus; observation of the previous edge's outputs happens first.
    task automatic cycle(input bit rst, input bit en, input bit msb, input bit ld, input bit [5:0] p);
        exp_t x;
        bit   tk;
        @(negedge clk);
        obs_early = bus.early;
        obs_any   = bus.early | bus.prompt | bus.late;
        obs_idx   = int'(bus.chip_index);
        if (bus.epoch) epoch_seen++;
        reset       = rst;
        bus.enable  = en;
        bus.dds_msb = msb;
        bus.load    = ld;
        bus.prn     = p;
        if (!rst) begin
            msb_prev = 1'b0; n = 0; prn_m = 1; ep_m = 1'b0;
        end else if (ld) begin
            msb_prev = msb; n = 0; prn_m = int'(p); ep_m = 1'b0;
        end else begin
            tk = msb && !msb_prev && en;
            msb_prev = msb;
            ep_m = 1'b0;
            if (tk) begin
                n++;
                ep_m = (n % 2046 == 0);
            end
        end
        x.e   = mbit(n - 1);
        x.p   = mbit(n - 2);
        x.l   = mbit(n - 3);
        x.ep  = ep_m;
        x.idx = (n / 2) % 1023;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        repeat ($urandom_range(1, 2)) cycle(1, 1, 1, 0, 6'd0);
        repeat ($urandom_range(1, 2)) cycle(1, 1, 0, 0, 6'd0);
    endtask

    // Monitor: compares every registered output against the model one edge after stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                checks++;
                if (bus.early !== x.e || bus.prompt !== x.p || bus.late !== x.l ||
                    bus.epoch !== x.ep || bus.chip_index !== 10'(x.idx)) begin
                    fails++;
                    $display("FAIL outputs @%0t: e/p/l/epoch=%b%b%b%b idx=%0d, expected %b%b%b%b idx=%0d",
                             $time, bus.early, bus.prompt, bus.late, bus.epoch, bus.chip_index,
                             x.e, x.p, x.l, x.ep, x.idx);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the end of the test");
        $fatal(1, "timeout");
    end

    initial begin
        bit [9:0] got1;
        bit [9:0] got2;
        int       ones;
        int       idx_before;
        int       g1[11];
        int       g2[11];
        int       f1;
        int       f2;

        for (int p = 1; p <= 32; p++) begin
            for (int s = 1; s <= 10; s++) begin g1[s] = 1; g2[s] = 1; end
            for (int c = 0; c < 1023; c++) begin
                code_tab[p][c] = bit'(g1[10] ^ g2[tap_a[p]] ^ g2[tap_b[p]]);
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int s = 10; s >= 2; s--) begin g1[s] = g1[s-1]; g2[s] = g2[s-1]; end
                g1[1] = f1;
                g2[1] = f2;
            end
        end

        bus.enable = 1'b1; bus.dds_msb = 1'b0; bus.load = 1'b0; bus.prn = 6'd0;

        // Reset with the dds toggling underneath it.
        for (int i = 0; i < 3; i++) cycle(0, 1, bit'(i % 2), 0, 6'd0);
        cycle(1, 1, 0, 0, 6'd0);
        check("no_epoch_in_reset", epoch_seen, 0);

        // PRN 1: first ten chips must be 1440 octal.
        cycle(1, 1, 0, 1, 6'd1);
        got1 = '0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t % 2 == 1) got1[9 - (t - 1) / 2] = obs_early;
        end
        check("prn1_first10_chips", int'(got1), 'o1440);

        // PRN 2: 1620 octal, a single epoch across the wrap, then the code repeats.
        cycle(1, 1, 0, 1, 6'd2);
        epoch_seen = 0;
        got1 = '0;
        got2 = '0;
        for (int t = 1; t <= 2100; t++) begin
            tick();
            if (t % 2 == 1 && t <= 19) got1[9 - (t - 1) / 2] = obs_early;
            if (t % 2 == 1 && t >= 2047 && t <= 2065) got2[9 - (t - 2047) / 2] = obs_early;
        end
        check("prn2_first10_chips", int'(got1), 'o1620);
        check("prn2_repeat_after_wrap", int'(got2), 'o1620);
        check("prn2_epoch_count", epoch_seen, 1);

        // Load coincident with a tick; the tick is dropped.
        cycle(1, 1, 1, 1, 6'd3);
        cycle(1, 1, 0, 0, 6'd0);
        cycle(1, 1, 0, 0, 6'd0);
        check("coincident_load_idx", obs_idx, 0);
        for (int t = 0; t < 1000; t++) tick();
        cycle(1, 1, 0, 0, 6'd0);
        check("chip_500_reached", obs_idx, 500);

        // Mid-epoch load then mid-epoch reset: restart with no epoch.
        epoch_seen = 0;
        cycle(1, 1, 0, 1, 6'd5);
        for (int t = 0; t < 40; t++) tick();
        cycle(0, 1, 1, 0, 6'd0);
        cycle(1, 1, 1, 0, 6'd0);
        for (int t = 0; t < 30; t++) tick();
        cycle(1, 1, 0, 0, 6'd0);
        check("no_epoch_on_restart", epoch_seen, 0);

        // Freeze while the dds keeps toggling.
        idx_before = obs_idx;
        for (int i = 0; i < 50; i++) cycle(1, 0, bit'(i % 2), 0, 6'd0);
        cycle(1, 0, 0, 0, 6'd0);
        check("frozen_idx", obs_idx, idx_before);
        for (int t = 0; t < 20; t++) tick();

        // Two long high pulses must count as exactly two ticks.
        cycle(1, 1, 0, 1, 6'd7);
        repeat (100) cycle(1, 1, 1, 0, 6'd0);
        cycle(1, 1, 0, 0, 6'd0);
        repeat (100) cycle(1, 1, 1, 0, 6'd0);
        cycle(1, 1, 0, 0, 6'd0);
        cycle(1, 1, 0, 0, 6'd0);
        check("held_high_two_ticks_idx", obs_idx, 1);

        // Unsupported PRNs: flat code, counters and epoch still run.
        foreach (tap_a[k]) begin
            bit [5:0] bad;
            if (k > 1) break;
            bad = (k == 0) ? 6'd0 : 6'd40;
            cycle(1, 1, 0, 1, bad);
            epoch_seen = 0;
            ones = 0;
            for (int t = 0; t < 2050; t++) begin
                tick();
                if (obs_any) ones++;
            end
            check("bad_prn_code_zero", ones, 0);
            check("bad_prn_epoch_count", epoch_seen, 1);
            check("bad_prn_idx", obs_idx, 2);
        end

        // Random PRNs and run lengths.
        for (int k = 0; k < 6; k++) begin
            cycle(1, 1, 0, 1, 6'($urandom_range(1, 32)));
            repeat ($urandom_range(50, 300)) tick();
        end

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
